// File: rtl/key_pkg.sv
// Shared encodings for the key event controller: event types, classifier
// states and the per-key timer width.
package key_pkg;

    localparam int TIMER_W = 26;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'b00,
        EVT_SHORT  = 2'b01,
        EVT_LONG   = 2'b10,
        EVT_DOUBLE = 2'b11
    } evt_type_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HELD     = 3'd1,
        ST_LONGHELD = 3'd2,
        ST_WAITDBL  = 3'd3,
        ST_HELD2    = 3'd4
    } key_state_e;

endpackage

// File: rtl/key_event_ctrl_if.sv
// Event output channel: valid/ready handshake carrying {key, type}.
interface key_event_ctrl_if #(
    parameter int KEY_W = 2
) ();

    logic                 evt_valid;
    logic                 evt_ready;
    logic [KEY_W-1:0]     evt_key;
    key_pkg::evt_type_e   evt_type;

    modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
    modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);

endinterface

// File: rtl/key_evt_fsm.sv
// Per-key press classifier: turns debounced press/release pulses into
// SHORT, LONG or DOUBLE events (one-cycle emit, EVT_NONE otherwise).
module key_evt_fsm
    import key_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 15_000_000
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      press_down_i,
    input  logic      press_up_i,
    output evt_type_e evt_o
);

    localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DCLICK_LAST = TIMER_W'(DCLICK_CYCLES - 1);

    key_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // State and timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state and event; each state looks only at the input it cares about.
    always_comb begin
        state_d = state_q;
        evt_o   = EVT_NONE;
        case (state_q)
            ST_IDLE: begin
                if (press_down_i) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (press_up_i) begin
                    state_d = ST_WAITDBL;
                end else if (timer_q == LONG_LAST) begin
                    evt_o   = EVT_LONG;
                    state_d = ST_LONGHELD;
                end
            end
            ST_LONGHELD: begin
                if (press_up_i) state_d = ST_IDLE;
            end
            ST_WAITDBL: begin
                if (press_down_i) begin
                    evt_o   = EVT_DOUBLE;
                    state_d = ST_HELD2;
                end else if (timer_q == DCLICK_LAST) begin
                    evt_o   = EVT_SHORT;
                    state_d = ST_IDLE;
                end
            end
            ST_HELD2: begin
                if (press_up_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Timer restarts on every state entry and only runs where a timeout exists.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == ST_HELD || state_q == ST_WAITDBL) begin
            timer_d = timer_q + TIMER_W'(1);
        end else begin
            timer_d = '0;
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: per-key classifiers feed one-entry pending slots,
// a round-robin arbiter moves slots into a show-ahead event FIFO.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 15_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] press_down,
    input  logic [NUM_KEYS-1:0] press_up,
    key_event_ctrl_if.master    evt,
    output logic                overflow
);

    localparam int KEY_W = $clog2(NUM_KEYS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    evt_type_e          emit   [NUM_KEYS];
    evt_type_e          slot_q [NUM_KEYS];
    evt_type_e          slot_d [NUM_KEYS];
    logic               drop;
    logic               overflow_q;
    logic [KEY_W-1:0]   last_grant_q;
    logic [KEY_W-1:0]   arb_idx;
    logic [KEY_W-1:0]   gidx;
    logic               grant;
    logic               pop;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [KEY_W-1:0]   mem_key_q  [FIFO_DEPTH];
    evt_type_e          mem_type_q [FIFO_DEPTH];

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_evt_fsm #(
            .LONG_CYCLES  (LONG_CYCLES),
            .DCLICK_CYCLES(DCLICK_CYCLES)
        ) u_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .press_down_i(press_down[k]),
            .press_up_i  (press_up[k]),
            .evt_o       (emit[k])
        );
    end

    // Round-robin pick of one pending slot, starting after the last winner.
    always_comb begin
        grant   = 1'b0;
        gidx    = '0;
        arb_idx = '0;
        for (int i = 1; i <= NUM_KEYS; i++) begin
            arb_idx = KEY_W'((int'(last_grant_q) + i) % NUM_KEYS);
            if (!grant && slot_q[arb_idx] != EVT_NONE) begin
                grant = 1'b1;
                gidx  = arb_idx;
            end
        end
        // The registered count gates pushes, so a same-cycle pop never frees room.
        if (count_q == CNT_W'(FIFO_DEPTH)) grant = 1'b0;
    end

    // Slot update: granted slot empties, a new event fills an empty slot or is dropped.
    always_comb begin
        drop = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            slot_d[k] = slot_q[k];
            if (grant && gidx == KEY_W'(k)) slot_d[k] = EVT_NONE;
            if (emit[k] != EVT_NONE) begin
                if (slot_q[k] == EVT_NONE) slot_d[k] = emit[k];
                else                       drop      = 1'b1;
            end
        end
    end

    assign pop = (count_q != '0) && evt.evt_ready;

    // Control state: slots, arbiter pointer, overflow pulse, FIFO pointers and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_KEYS; k++) slot_q[k] <= EVT_NONE;
            last_grant_q <= KEY_W'(NUM_KEYS - 1);
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) slot_q[k] <= slot_d[k];
            overflow_q <= drop;
            if (grant) begin
                last_grant_q <= gidx;
                wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({grant, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful under the count, so no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            mem_key_q[wr_ptr_q]  <= gidx;
            mem_type_q[wr_ptr_q] <= slot_q[gidx];
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_key   = mem_key_q[rd_ptr_q];
    assign evt.evt_type  = mem_type_q[rd_ptr_q];
    assign overflow      = overflow_q;

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 The block SHALL have the parameter NUM_KEYS, default 4, giving the number of debounced keys serviced (2..8).
REQ-002 The block SHALL have the parameter LONG_CYCLES, default 50_000_000, giving the hold time that classifies a press as long.
REQ-003 The block SHALL have the parameter DCLICK_CYCLES, default 15_000_000, giving the maximum release-to-press gap for a double click.
REQ-004 The block SHALL have the parameter FIFO_DEPTH, default 4, giving the event FIFO entries (power of 2).
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the port press_down, input, NUM_KEYS bits: one-cycle debounced press pulse per key.
REQ-008 The block SHALL have the port press_up, input, NUM_KEYS bits: one-cycle debounced release pulse per key.
REQ-009 The block SHALL have the port evt_valid, output, 1 bit: FIFO head holds an event.
REQ-010 The block SHALL have the port evt_ready, input, 1 bit: consumer accepts the head.
REQ-011 The block SHALL have the port evt_key, output, $clog2(NUM_KEYS) bits: key index of the head event.
REQ-012 The block SHALL have the port evt_type, output, 2 bits: 01 SHORT, 10 LONG, 11 DOUBLE.
REQ-013 The block SHALL have the port overflow, output, 1 bit: one-cycle pulse when an event is dropped.

Function
REQ-014 Each key SHALL have its own classifier FSM with states IDLE, HELD, LONGHELD, WAITDBL and HELD2, plus a 26-bit timer that is cleared on every state entry.
REQ-015 In IDLE, press_down SHALL cause a transition to HELD, and press_up SHALL be ignored.
REQ-016 In HELD, press_up SHALL cause a transition to WAITDBL; otherwise, when the timer equals LONG_CYCLES-1, the FSM SHALL emit LONG and go to LONGHELD; press_up takes priority over timer expiry.
REQ-017 In LONGHELD, press_up SHALL cause a transition to IDLE with no event.
REQ-018 In WAITDBL, press_down SHALL emit DOUBLE and go to HELD2; otherwise, when the timer equals DCLICK_CYCLES-1, the FSM SHALL emit SHORT and go to IDLE; press_down takes priority over timer expiry.
REQ-019 In HELD2, press_up SHALL cause a transition to IDLE with no event; HELD2 SHALL never time out.
REQ-020 Each state SHALL evaluate only its relevant input, so that a simultaneous press_down and press_up for one key resolves per REQ-015 to REQ-019.
REQ-021 An emitted event SHALL set that key's one-entry pending slot at the next edge; if the slot is already full, the new event SHALL be dropped and overflow SHALL pulse for one cycle.
REQ-022 The round-robin arbiter SHALL grant at most one pending slot per cycle, searching from last_grant+1 modulo NUM_KEYS, and only when the FIFO count is below FIFO_DEPTH.
REQ-023 A grant SHALL write {key, type} into the FIFO and clear the granted slot at the same edge; a slot set and granted in the same cycle SHALL NOT occur, because a slot is granted only the cycle after it is set.
REQ-024 Latency SHALL be: event condition in cycle T, pending set in T+1, FIFO written at the end of T+1, and evt_valid high in T+2 when the FIFO and other slots are empty.
REQ-025 The FIFO SHALL be show-ahead, and a pop SHALL occur when evt_valid and evt_ready are both high.
REQ-026 A simultaneous push and pop SHALL keep the FIFO count unchanged.
REQ-027 A push SHALL NOT occur while the registered count equals FIFO_DEPTH, even if a pop occurs in that cycle.
REQ-028 evt_key and evt_type SHALL be don't-care while evt_valid is low.

Reset
REQ-029 On rst_n low, the block SHALL immediately set all FSMs to IDLE, timers to 0, pending slots to empty, the FIFO to empty, evt_valid=0, overflow=0 and last_grant=NUM_KEYS-1, so that key 0 is searched first.
REQ-030 Reset mid-operation SHALL discard all in-flight and queued events, and a press_up arriving after reset release SHALL produce no event.

Structure
REQ-031 The shared package key_pkg SHALL hold the event-type encodings, the FSM state encodings and the timer width constant.
REQ-032 Per-key classification SHALL be implemented in the sub-module key_evt_fsm, instantiated NUM_KEYS times; the arbiter and FIFO SHALL remain in key_event_ctrl.

Verification (LONG_CYCLES=20, DCLICK_CYCLES=10, NUM_KEYS=4, FIFO_DEPTH=4)
REQ-033 Short press: key0 down at cycle 0, up at cycle 5 -> one event {0, SHORT} with evt_valid rising at cycle 17; no other event.
REQ-034 Long press: key1 down at cycle 0, held 30 cycles -> one event {1, LONG} with evt_valid at cycle 22; release produces no event.
REQ-035 Double click: key2 down at 0, up at 3, down at 8, up at 12 -> exactly one event {2, DOUBLE} with evt_valid at cycle 10; no SHORT.
REQ-036 Arbitration: all four keys emit SHORT in the same cycle with evt_ready=1 -> keys 0,1,2,3 delivered on consecutive cycles.
REQ-037 Backpressure: evt_ready=0, then 8 SHORT events (two per key, staggered) -> the FIFO holds 4 and the slots hold 4; a 9th event on key0 pulses overflow once; raising evt_ready then delivers exactly 8 events in round-robin order.
REQ-038 Reset mid-operation: assert rst_n during HELD with 2 FIFO entries queued -> evt_valid=0 within the reset cycle; release after reset yields no event.
